// File: rtl/counter.sv
// Loadable up-counter with asynchronous active-high clear.
// A load wins over an increment, and the count wraps modulo 2^WIDHT.
module counter #(
  parameter int WIDHT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDHT-1:0] cnt_in,
  output logic [WIDHT-1:0] cnt_out
);

  logic [WIDHT-1:0] cnt_q;
  logic [WIDHT-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cnt_in;
    end else if (enab) begin
      cnt_d = cnt_q + WIDHT'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter at WIDHT=5: stimulus pushes expected values,
// a monitor pops one per clock edge and compares.
module tb_counter;
  localparam int W   = 5;
  localparam int MOD = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic         enab = 1'b0;
  logic [W-1:0] cnt_in = '0;
  logic [W-1:0] cnt_out;

  int total = 0;
  int bad   = 0;
  int model = 0;
  logic [W-1:0] exp_q[$];

  counter #(.WIDHT(W)) dut (
    .clk(clk), .rst(rst), .load(load), .enab(enab),
    .cnt_in(cnt_in), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: reset clears, otherwise load replaces, enable adds one mod 32.
  task automatic step(input logic r, input logic ld, input logic en, input logic [W-1:0] din);
    @(negedge clk);
    rst = r; load = ld; enab = en; cnt_in = din;
    if (r) model = 0;
    else if (ld) model = int'(din);
    else if (en) model = (model + 1) % MOD;
    exp_q.push_back(W'(model));
  endtask

  // Reset raised between edges must clear the output before the next edge.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", cnt_out, '0);
    model = 0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("edge", cnt_out, exp_q.pop_front());
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 rst = 1'b1;
    #1 check("reset_init", cnt_out, '0);
    step(1, 0, 0, 5'h00);
    step(1, 1, 1, 5'h1F);

    step(0, 1, 1, 5'h15);
    step(0, 1, 1, 5'h0A);
    step(0, 1, 1, 5'h1F);

    step(1, 1, 1, 5'h1F);
    step(0, 1, 1, 5'h15);
    mid_reset();
    step(1, 1, 1, 5'h1F);

    step(0, 1, 0, 5'h1F);
    step(0, 0, 1, 5'h00);

    step(0, 1, 0, 5'h03);
    repeat (3) step(0, 0, 1, 5'h03);
    step(0, 0, 0, 5'h11);
    step(0, 0, 1, 5'h1F);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        mid_reset();
      end else begin
        step(($urandom_range(0, 24) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1),
             W'($urandom_range(0, MOD - 1)));
      end
    end

    step(0, 0, 0, 5'h00);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
